// File: rtl/seg_adder_pkg.sv
// seg_adder_pkg
//   Shared types and helpers for the segmented adder/subtractor.
//   - state_e     : controller states (IDLE, RUN, DONE)
//   - chunk_count : number of K-bit chunks in an N-bit operand
//   - cnt_width   : width of the chunk counter, never less than one bit
package seg_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A non-positive K is rejected at elaboration by the top level. Guarding
    // the division here keeps constant evaluation from dividing by zero first.
    function automatic int chunk_count(input int n, input int k);
        return (k < 1) ? 1 : (n / k);
    endfunction

    function automatic int cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/seg_adder_add_chunk.sv
// add_chunk
//   Combinational K-bit ripple-carry adder; the width-generic form of the
//   original 4-bit adder. One instance is shared across all chunks.
//   Ports:
//     a, b : K-bit addends
//     cin  : carry in
//     sum  : K-bit sum
//     cout : carry out of the top bit
module add_chunk #(
    parameter int K = 4
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] sum,
    output logic         cout
);

    logic [K:0] carry;

    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < K; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[K];
    end

endmodule

// File: rtl/seg_adder.sv
// seg_adder
//   Multi-cycle adder/subtractor. An N-bit operation runs K bits per clock,
//   LSB chunk first, through one shared add_chunk instance. Subtraction is
//   done as x + ~y + ~ci, so cu reads as "no borrow" in subtract mode.
//   Ports:
//     clk   : rising-edge clock
//     rst   : asynchronous active-high reset
//     start : request, sampled only when not busy (IDLE or DONE)
//     sub   : 0 = add, 1 = subtract; sampled with start
//     x, y  : N-bit operands; sampled with start
//     ci    : carry-in / borrow-in; sampled with start
//     busy  : operation in progress
//     done  : one-cycle pulse after the result registers update
//     s     : registered N-bit result
//     cu    : carry-out (add) or no-borrow (sub)
//     ov    : two's-complement signed overflow
module seg_adder
    import seg_adder_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cu,
    output logic         ov
);

    localparam int CHUNKS = chunk_count(N, K);
    localparam int CW     = cnt_width(CHUNKS);
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    generate
        if (K < 1 || (N % K) != 0) begin : g_bad_param
            $error("seg_adder: N must be a positive multiple of K");
        end
    endgenerate

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Operand registers shift right one chunk per RUN edge, so the active
    // chunk always sits in bits [K-1:0]. On the last chunk those bits hold the
    // original operand MSB chunk, which is what the overflow rule needs.
    logic [N-1:0]  xa_q, xa_d;
    logic [N-1:0]  ya_q, ya_d;
    logic          c_q, c_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  s_q, s_d;
    logic          cu_q, cu_d;
    logic          ov_q, ov_d;

    logic [K-1:0]  sum_ch;
    logic          cout_ch;
    logic [N+K-1:0] acc_cat;
    logic [N-1:0]  acc_new;

    add_chunk #(.K(K)) u_add_chunk (
        .a    (xa_q[K-1:0]),
        .b    (ya_q[K-1:0]),
        .cin  (c_q),
        .sum  (sum_ch),
        .cout (cout_ch)
    );

    // The fresh chunk enters the accumulator from the top; after CHUNKS
    // shifts chunk 0 has reached bits [K-1:0]. This also covers K == N.
    always_comb begin
        acc_cat = {sum_ch, acc_q};
        acc_new = acc_cat[N+K-1:K];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xa_d    = xa_q;
        ya_d    = ya_q;
        c_d     = c_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cu_d    = cu_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    xa_d    = x;
                    ya_d    = sub ? ~y : y;
                    c_d     = sub ? ~ci : ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d   = cout_ch;
                acc_d = acc_new;
                xa_d  = xa_q >> K;
                ya_d  = ya_q >> K;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = acc_new;
                    cu_d    = cout_ch;
                    ov_d    = (xa_q[K-1] == ya_q[K-1]) && (sum_ch[K-1] != xa_q[K-1]);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            s_q     <= '0;
            cu_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cu_q    <= cu_d;
            ov_q    <= ov_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cu   = cu_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_seg_adder.sv
// tb_seg_adder
//   Self-checking bench for seg_adder. Instance A is N=16,K=4; instance B is
//   N=16,K=16. Expected results are queued when an operation is issued and
//   popped when the selected instance pulses done.
module tb_seg_adder;

    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] s;
        logic         cu;
        logic         ov;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic         sub = 1'b0;
    logic         ci = 1'b0;
    logic [N-1:0] x = '0;
    logic [N-1:0] y = '0;

    logic         busy_a, done_a, cu_a, ov_a;
    logic [N-1:0] s_a;
    logic         busy_b, done_b, cu_b, ov_b;
    logic [N-1:0] s_b;

    bit           sel = 1'b0;   // 0: instance A (K=4), 1: instance B (K=16)
    logic         busy_o, done_o, cu_o, ov_o;
    logic [N-1:0] s_o;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_adder #(.N(16), .K(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .sub(sub), .x(x), .y(y), .ci(ci),
        .busy(busy_a), .done(done_a), .s(s_a), .cu(cu_a), .ov(ov_a)
    );

    seg_adder #(.N(16), .K(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .sub(sub), .x(x), .y(y), .ci(ci),
        .busy(busy_b), .done(done_b), .s(s_b), .cu(cu_b), .ov(ov_b)
    );

    assign busy_o = sel ? busy_b : busy_a;
    assign done_o = sel ? done_b : done_a;
    assign s_o    = sel ? s_b    : s_a;
    assign cu_o   = sel ? cu_b   : cu_a;
    assign ov_o   = sel ? ov_b   : ov_a;

    function automatic res_t model(input bit op_sub, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic cin);
        res_t       r;
        logic [N:0] w;
        if (!op_sub) begin
            w    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
            r.s  = w[N-1:0];
            r.cu = w[N];
            r.ov = (a[N-1] == b[N-1]) && (r.s[N-1] != a[N-1]);
        end else begin
            r.s  = a - b - {{(N-1){1'b0}}, cin};
            r.cu = ({1'b0, a} >= ({1'b0, b} + {{N{1'b0}}, cin}));
            r.ov = (a[N-1] != b[N-1]) && (r.s[N-1] != a[N-1]);
        end
        return r;
    endfunction

    // Drive one request at a negedge, queue its expected result, and leave
    // at the negedge after the accepting edge with start dropped.
    task automatic issue(input bit op_sub, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input res_t e);
        sub = op_sub; x = a; y = b; ci = cin;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        acc_cyc = cyc;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Waits (bounded) for done on the selected instance, counting busy cycles.
    task automatic wait_done(output bit got, output int busy_cnt, output int done_cyc);
        got = 1'b0; busy_cnt = 0; done_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o === 1'b1) begin
                got = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (busy_o === 1'b1) busy_cnt++;
            @(negedge clk);
        end
    endtask

    function automatic res_t pop_exp();
        res_t e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = N'($urandom); y = N'($urandom);
            sub = 1'($urandom); ci = 1'($urandom);
            start_a = 1'($urandom); start_b = 1'($urandom);
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            checks++;
            if ({s_o, cu_o, ov_o, busy_o, done_o} !== {{N{1'b0}}, 4'b0000}) begin
                errors++;
                $display("FAIL reset_values inst=%0d got s=%h cu=%b ov=%b busy=%b done=%b want all 0",
                         k, s_o, cu_o, ov_o, busy_o, done_o);
            end
        end
        sel = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle got busy=%b done=%b want 0 0", busy_o, done_o);
        end
    endtask

    // Directed table run on instance A; expected values are hand-derived.
    task automatic test_table(input bit op_sub);
        logic [N-1:0] ta[3];
        logic [N-1:0] tb[3];
        logic         tc[3];
        res_t         te[3];
        res_t         e;
        bit           got;
        int           bc, dc;
        sel = 1'b0;
        if (!op_sub) begin
            ta = '{16'h00FF, 16'hFFFF, 16'h7FFF};
            tb = '{16'h0001, 16'hFFFF, 16'h0001};
            tc = '{1'b0, 1'b1, 1'b0};
            te = '{'{16'h0100, 1'b0, 1'b0}, '{16'hFFFF, 1'b1, 1'b0}, '{16'h8000, 1'b0, 1'b1}};
        end else begin
            ta = '{16'h0005, 16'h8000, 16'h0010};
            tb = '{16'h0007, 16'h0001, 16'h0003};
            tc = '{1'b0, 1'b0, 1'b1};
            te = '{'{16'hFFFE, 1'b0, 1'b0}, '{16'h7FFF, 1'b1, 1'b1}, '{16'h000C, 1'b1, 1'b0}};
        end
        for (int i = 0; i < 3; i++) begin
            issue(op_sub, ta[i], tb[i], tc[i], te[i]);
            wait_done(got, bc, dc);
            e = pop_exp();
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL %s_%0d_timeout no done within bound", op_sub ? "sub" : "add", i);
                continue;
            end
            checks++;
            if (bc != 4 || (dc - acc_cyc) != 4) begin
                errors++;
                $display("FAIL %s_%0d_latency got busy=%0d done_at=%0d want 4 4",
                         op_sub ? "sub" : "add", i, bc, dc - acc_cyc);
            end
            checks++;
            if ({s_o, cu_o, ov_o} !== e) begin
                errors++;
                $display("FAIL %s_%0d_result got s=%h cu=%b ov=%b want s=%h cu=%b ov=%b",
                         op_sub ? "sub" : "add", i, s_o, cu_o, ov_o, e.s, e.cu, e.ov);
            end
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_%0d_done_width got done=%b want 0", op_sub ? "sub" : "add", i, done_o);
            end
        end
    endtask

    task automatic test_add();
        test_table(1'b0);
    endtask

    task automatic test_sub();
        test_table(1'b1);
    endtask

    task automatic test_start_during_run();
        res_t e;
        bit   got;
        int   bc, dc, extra;
        sel = 1'b0;
        issue(1'b0, 16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0});
        @(negedge clk);
        sub = 1'b1; x = 16'hFFFF; y = 16'h0F0F; ci = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(got, bc, dc);
        e = pop_exp();
        checks++;
        if (!got || (dc - acc_cyc) != 4) begin
            errors++;
            $display("FAIL run_start_timing got done=%b at %0d want done at 4", got, dc - acc_cyc);
        end
        checks++;
        if ({s_o, cu_o, ov_o} !== e) begin
            errors++;
            $display("FAIL run_start_result got s=%h cu=%b ov=%b want s=%h cu=%b ov=%b",
                     s_o, cu_o, ov_o, e.s, e.cu, e.ov);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL run_start_ignored got %0d busy/done cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        res_t e1, e2, e;
        bit   got;
        int   bc, d1, d2;
        sel = 1'b0;
        e1 = '{16'h2143, 1'b0, 1'b0};
        e2 = '{16'h00FF, 1'b1, 1'b0};
        sub = 1'b0; x = 16'h1234; y = 16'h0F0F; ci = 1'b0; start_a = 1'b1;
        exp_q.push_back(e1);
        @(negedge clk);
        sub = 1'b1; x = 16'h0100; y = 16'h0001; ci = 1'b0;
        exp_q.push_back(e2);
        wait_done(got, bc, d1);
        e = pop_exp();
        checks++;
        if (!got || {s_o, cu_o, ov_o} !== e) begin
            errors++;
            $display("FAIL b2b_first got done=%b s=%h cu=%b ov=%b want s=%h cu=%b ov=%b",
                     got, s_o, cu_o, ov_o, e.s, e.cu, e.ov);
        end
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || s_o !== e1.s) begin
            errors++;
            $display("FAIL b2b_hold got busy=%b s=%h want busy=1 s=%h", busy_o, s_o, e1.s);
        end
        wait_done(got, bc, d2);
        e = pop_exp();
        checks++;
        if (!got || (d2 - d1) != 5) begin
            errors++;
            $display("FAIL b2b_spacing got done=%b spacing=%0d want 5", got, d2 - d1);
        end
        checks++;
        if ({s_o, cu_o, ov_o} !== e) begin
            errors++;
            $display("FAIL b2b_second got s=%h cu=%b ov=%b want s=%h cu=%b ov=%b",
                     s_o, cu_o, ov_o, e.s, e.cu, e.ov);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        res_t e;
        bit   got;
        int   bc, dc, seen;
        sel = 1'b0;
        sub = 1'b0; x = 16'hAAAA; y = 16'h5555; ci = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({s_o, cu_o, ov_o, busy_o, done_o} !== {{N{1'b0}}, 4'b0000}) begin
            errors++;
            $display("FAIL mid_reset_async got s=%h cu=%b ov=%b busy=%b done=%b want all 0",
                     s_o, cu_o, ov_o, busy_o, done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_no_done got %0d busy/done cycles want 0", seen);
        end
        issue(1'b0, 16'h4000, 16'h4000, 1'b0, '{16'h8000, 1'b0, 1'b1});
        wait_done(got, bc, dc);
        e = pop_exp();
        checks++;
        if (!got || {s_o, cu_o, ov_o} !== e) begin
            errors++;
            $display("FAIL mid_reset_fresh got done=%b s=%h cu=%b ov=%b want s=%h cu=%b ov=%b",
                     got, s_o, cu_o, ov_o, e.s, e.cu, e.ov);
        end
        @(negedge clk);
    endtask

    task automatic test_single_cycle();
        res_t e;
        bit   got;
        int   bc, dc;
        sel = 1'b1;
        issue(1'b0, 16'h1234, 16'h4321, 1'b1, '{16'h5556, 1'b0, 1'b0});
        wait_done(got, bc, dc);
        e = pop_exp();
        checks++;
        if (!got || bc != 1 || (dc - acc_cyc) != 1) begin
            errors++;
            $display("FAIL k16_latency got done=%b busy=%0d done_at=%0d want 1 1 1",
                     got, bc, dc - acc_cyc);
        end
        checks++;
        if ({s_o, cu_o, ov_o} !== e) begin
            errors++;
            $display("FAIL k16_result got s=%h cu=%b ov=%b want s=%h cu=%b ov=%b",
                     s_o, cu_o, ov_o, e.s, e.cu, e.ov);
        end
        @(negedge clk);
    endtask

    task automatic test_random(input bit which, input int count);
        res_t         e;
        bit           got, op_sub;
        int           bc, dc;
        logic [N-1:0] a, b;
        logic         cin;
        sel = which;
        for (int i = 0; i < count; i++) begin
            op_sub = 1'($urandom);
            a = N'($urandom);
            b = N'($urandom);
            cin = 1'($urandom);
            if ((i % 16) == 0) a = (i % 32 == 0) ? 16'hFFFF : 16'h8000;
            issue(op_sub, a, b, cin, model(op_sub, a, b, cin));
            wait_done(got, bc, dc);
            e = pop_exp();
            checks++;
            if (!got || {s_o, cu_o, ov_o} !== e) begin
                errors++;
                $display("FAIL rand_k%0d_%0d %s x=%h y=%h ci=%b got done=%b s=%h cu=%b ov=%b want s=%h cu=%b ov=%b",
                         which ? 16 : 4, i, op_sub ? "sub" : "add", a, b, cin,
                         got, s_o, cu_o, ov_o, e.s, e.cu, e.ov);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid();
        test_single_cycle();
        test_random(1'b1, 1000);
        test_random(1'b0, 200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
